// File: rtl/piso_pkg.sv
// Shared definitions for the 4-bit parallel-in serial-out transmitter:
// FSM state encoding and the default word width.
package piso_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } piso_state_e;

   localparam int PISO_DEFAULT_WIDTH = 4;

endpackage : piso_pkg

// File: rtl/piso_bit_counter.sv
// Bit-position counter for one serial frame; counts 0..WIDTH-1 on the falling
// clock edge and flags the last bit position.
module piso_bit_counter #(
   parameter int WIDTH = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam int CNT_W = $clog2(WIDTH);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Clear has priority so a back-to-back load restarts at bit 0.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = {CNT_W{1'b0}};
      end else if (en) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Counter register, updated on the falling edge.
   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= {CNT_W{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc = (cnt_q == CNT_W'(WIDTH - 1));

endmodule : piso_bit_counter

// File: rtl/piso_4bit_tx.sv
// Parallel-in serial-out transmitter: accepts a WIDTH-bit word and shifts it
// out one bit per falling clock edge, with frame_start/done markers.
module piso_4bit_tx
   import piso_pkg::*;
#(
   parameter int WIDTH     = PISO_DEFAULT_WIDTH,
   parameter int MSB_FIRST = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             sout,
   output logic             sout_valid,
   output logic             frame_start,
   output logic             done
);

   piso_state_e      state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic             sout_q, sout_d;
   logic             sout_valid_q, sout_valid_d;
   logic             frame_start_q, frame_start_d;

   logic             cnt_clr_s;
   logic             cnt_en_s;
   logic             cnt_tc_s;
   logic             accept_s;
   logic             first_bit_s;
   logic [WIDTH-1:0] rest_s;
   logic             next_bit_s;
   logic [WIDTH-1:0] shifted_s;

   piso_bit_counter #(
      .WIDTH (WIDTH)
   ) u_bit_counter (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (cnt_clr_s),
      .en    (cnt_en_s),
      .tc    (cnt_tc_s)
   );

   // The shift register holds only the bits not yet presented on sout.
   always_comb begin
      first_bit_s = 1'b0;
      rest_s      = {WIDTH{1'b0}};
      next_bit_s  = 1'b0;
      shifted_s   = {WIDTH{1'b0}};
      if (MSB_FIRST != 0) begin
         first_bit_s = din[WIDTH-1];
         rest_s      = {din[WIDTH-2:0], 1'b0};
         next_bit_s  = shreg_q[WIDTH-1];
         shifted_s   = {shreg_q[WIDTH-2:0], 1'b0};
      end else begin
         first_bit_s = din[0];
         rest_s      = {1'b0, din[WIDTH-1:1]};
         next_bit_s  = shreg_q[0];
         shifted_s   = {1'b0, shreg_q[WIDTH-1:1]};
      end
   end

   assign load_ready = (state_q == IDLE) || ((state_q == SHIFT) && cnt_tc_s);
   assign accept_s   = load_valid && load_ready;

   // Next-state and output-register logic.
   always_comb begin
      state_d       = state_q;
      shreg_d       = shreg_q;
      sout_d        = sout_q;
      sout_valid_d  = sout_valid_q;
      frame_start_d = frame_start_q;
      cnt_clr_s     = 1'b0;
      cnt_en_s      = 1'b0;

      case (state_q)
         IDLE: begin
            if (accept_s) begin
               state_d       = SHIFT;
               shreg_d       = rest_s;
               sout_d        = first_bit_s;
               sout_valid_d  = 1'b1;
               frame_start_d = 1'b1;
               cnt_clr_s     = 1'b1;
            end else begin
               sout_d        = 1'b0;
               sout_valid_d  = 1'b0;
               frame_start_d = 1'b0;
            end
         end
         SHIFT: begin
            if (!cnt_tc_s) begin
               shreg_d       = shifted_s;
               sout_d        = next_bit_s;
               frame_start_d = 1'b0;
               cnt_en_s      = 1'b1;
            end else if (load_valid) begin
               shreg_d       = rest_s;
               sout_d        = first_bit_s;
               sout_valid_d  = 1'b1;
               frame_start_d = 1'b1;
               cnt_clr_s     = 1'b1;
            end else begin
               state_d       = IDLE;
               shreg_d       = {WIDTH{1'b0}};
               sout_d        = 1'b0;
               sout_valid_d  = 1'b0;
               frame_start_d = 1'b0;
               cnt_clr_s     = 1'b1;
            end
         end
         default: begin
            state_d       = IDLE;
            shreg_d       = {WIDTH{1'b0}};
            sout_d        = 1'b0;
            sout_valid_d  = 1'b0;
            frame_start_d = 1'b0;
            cnt_clr_s     = 1'b1;
         end
      endcase
   end

   // State and output registers, updated on the falling edge.
   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         shreg_q       <= {WIDTH{1'b0}};
         sout_q        <= 1'b0;
         sout_valid_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         shreg_q       <= shreg_d;
         sout_q        <= sout_d;
         sout_valid_q  <= sout_valid_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign sout        = sout_q;
   assign sout_valid  = sout_valid_q;
   assign frame_start = frame_start_q;
   assign done        = (state_q == SHIFT) && cnt_tc_s;

endmodule : piso_4bit_tx

// File: tb/tb_piso_4bit_tx.sv
// Self-checking bench for piso_4bit_tx: an MSB-first and an LSB-first instance
// share stimulus; expected serial beats are queued at load time and popped per cycle.
module tb_piso_4bit_tx;

   typedef struct packed {
      logic sout;
      logic fs;
      logic dn;
   } beat_t;

   logic       clk;
   logic       rst_n;
   logic [3:0] din;
   logic       load_valid;

   logic m_ready, m_sout, m_valid, m_fs, m_done;
   logic l_ready, l_sout, l_valid, l_fs, l_done;

   beat_t q_m[$];
   beat_t q_l[$];

   int tests_run;
   int tests_failed;

   piso_4bit_tx #(.WIDTH(4), .MSB_FIRST(1)) dut_msb (
      .clk         (clk),
      .rst_n       (rst_n),
      .din         (din),
      .load_valid  (load_valid),
      .load_ready  (m_ready),
      .sout        (m_sout),
      .sout_valid  (m_valid),
      .frame_start (m_fs),
      .done        (m_done)
   );

   piso_4bit_tx #(.WIDTH(4), .MSB_FIRST(0)) dut_lsb (
      .clk         (clk),
      .rst_n       (rst_n),
      .din         (din),
      .load_valid  (load_valid),
      .load_ready  (l_ready),
      .sout        (l_sout),
      .sout_valid  (l_valid),
      .frame_start (l_fs),
      .done        (l_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {sout, sout_valid, frame_start, done, load_ready}
   function automatic logic [4:0] exp_vec(input logic have, input beat_t b);
      if (have) return {b.sout, 1'b1, b.fs, b.dn, b.dn};
      return 5'b00001;
   endfunction

   task automatic cmp(input string tag, input logic [4:0] obs, input logic [4:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s t=%0t observed={sout,vld,fs,done,rdy}=%b expected=%b", tag, $time, obs, exp);
      end
   endtask

   task automatic push_frame(input logic [3:0] w);
      for (int i = 0; i < 4; i++) begin
         q_m.push_back('{sout: w[3-i], fs: (i == 0), dn: (i == 3)});
         q_l.push_back('{sout: w[i],   fs: (i == 0), dn: (i == 3)});
      end
   endtask

   task automatic load(input logic [3:0] w);
      din        = w;
      load_valid = 1'b1;
      push_frame(w);
   endtask

   // Sample at the rising edge, midway between the falling active edges.
   task automatic cycle(input string tag);
      beat_t bm, bl;
      logic  hm, hl;
      @(posedge clk);
      hm = (q_m.size() > 0);
      hl = (q_l.size() > 0);
      bm = '0;
      bl = '0;
      if (hm) bm = q_m.pop_front();
      if (hl) bl = q_l.pop_front();
      cmp({tag, "_msb"}, {m_sout, m_valid, m_fs, m_done, m_ready}, exp_vec(hm, bm));
      cmp({tag, "_lsb"}, {l_sout, l_valid, l_fs, l_done, l_ready}, exp_vec(hl, bl));
   endtask

   task automatic check_idle_now(input string tag);
      cmp({tag, "_msb"}, {m_sout, m_valid, m_fs, m_done, m_ready}, 5'b00001);
      cmp({tag, "_lsb"}, {l_sout, l_valid, l_fs, l_done, l_ready}, 5'b00001);
   endtask

   initial begin
      logic [3:0] w;
      int         gap;
      tests_run    = 0;
      tests_failed = 0;
      rst_n        = 1'b0;
      din          = 4'b0000;
      load_valid   = 1'b0;

      // Reset state, including with load_valid asserted while in reset.
      cycle("reset");
      load_valid = 1'b1;
      din        = 4'b1111;
      cycle("reset_lv");
      load_valid = 1'b0;
      rst_n      = 1'b1;
      cycle("idle_after_reset");

      // Single frame 1011: MSB-first 1,0,1,1 and LSB-first 1,1,0,1, then idle.
      load(4'b1011);
      cycle("single");
      load_valid = 1'b0;
      din        = 4'b0000;
      repeat (5) cycle("single");

      // Back-to-back frames 1011 then 0110 with load_valid held high.
      load(4'b1011);
      repeat (4) cycle("b2b_first");
      load(4'b0110);
      cycle("b2b_second");
      load_valid = 1'b0;
      repeat (5) cycle("b2b_second");

      // din changes mid-frame must not disturb the frame in flight.
      load(4'b1111);
      cycle("hold");
      din        = 4'b0000;
      load_valid = 1'b0;
      repeat (5) cycle("hold");

      // Mid-frame reset after two bits: outputs drop without a clock edge.
      load(4'b1011);
      cycle("pre_reset");
      load_valid = 1'b0;
      cycle("pre_reset");
      #2;
      rst_n = 1'b0;
      #1;
      check_idle_now("async_reset");
      q_m.delete();
      q_l.delete();
      repeat (2) cycle("in_reset");
      rst_n = 1'b1;
      load(4'b0101);
      cycle("post_reset");
      load_valid = 1'b0;
      repeat (5) cycle("post_reset");

      // Random words with gaps of 0..2 idle cycles (0 means back-to-back).
      for (int k = 0; k < 8; k++) begin
         w   = 4'($urandom_range(0, 15));
         gap = $urandom_range(0, 2);
         load(w);
         cycle("rand");
         load_valid = 1'b0;
         din        = 4'($urandom_range(0, 15));
         repeat (3) cycle("rand");
         repeat (gap) cycle("rand_gap");
      end
      repeat (3) cycle("final_idle");

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule : tb_piso_4bit_tx
